// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: state encodings,
// default bus widths and a small state-classification helper.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  function automatic logic is_busy_state(input arb_state_t s);
    return (s == ARB_BUSY_I) || (s == ARB_BUSY_D);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Busy-cycle watchdog: counts cycles spent waiting for mem_ready and flags
// the cycle in which the count would reach TIMEOUT.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CNT_W'(TIMEOUT))) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Terminal fires on the waiting cycle whose increment completes TIMEOUT cycles.
  assign terminal = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory port between the fetch and
// load/store requesters, runs one valid/ready transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_reg, state_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic                mem_valid_reg, mem_valid_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                if_done_reg, if_done_next;
  logic                d_done_reg, d_done_next;
  logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic                busy_reg, busy_next;
  logic                err_reg, err_next;
  logic                in_busy;
  logic                timed_out;

  assign in_busy = is_busy_state(state_reg);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (!in_busy),
    .enable   (in_busy && !mem_ready),
    .terminal (timed_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ARB_IDLE;
      streak_reg    <= '0;
      mem_valid_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_done_reg   <= 1'b0;
      d_done_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      mem_valid_reg <= mem_valid_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_done_reg   <= if_done_next;
      d_done_reg    <= d_done_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    streak_next    = streak_reg;
    mem_valid_next = mem_valid_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_done_next   = 1'b0;
    d_done_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    err_next       = err_reg;

    unique case (state_reg)
      ARB_IDLE: begin
        // A saturated data streak hands the port to a waiting fetch first.
        if ((if_req && (streak_reg == STREAK_MAX)) || (if_req && !d_req)) begin
          state_next     = ARB_BUSY_I;
          mem_valid_next = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr;
          mem_wdata_next = '0;
          streak_next    = '0;
        end else if (d_req) begin
          state_next     = ARB_BUSY_D;
          mem_valid_next = 1'b1;
          mem_we_next    = d_we;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_wdata;
          if (!if_req) begin
            streak_next = '0;
          end else if (streak_reg != STREAK_MAX) begin
            streak_next = streak_reg + STREAK_W'(1);
          end
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ready || timed_out) begin
          state_next     = ARB_DONE;
          mem_valid_next = 1'b0;
          if (!mem_ready) begin
            err_next = 1'b1;
          end
          if (state_reg == ARB_BUSY_I) begin
            if_done_next  = 1'b1;
            if_rdata_next = mem_ready ? mem_rdata : '0;
          end else begin
            d_done_next = 1'b1;
            if (!mem_ready) begin
              d_rdata_next = '0;
            end else if (!mem_we_reg) begin
              d_rdata_next = mem_rdata;
            end
          end
        end
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase

    busy_next = (state_next != ARB_IDLE);
  end

  assign mem_valid   = mem_valid_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign if_done     = if_done_reg;
  assign d_done      = d_done_reg;
  assign if_rdata    = if_rdata_reg;
  assign d_rdata     = d_rdata_reg;
  assign busy        = busy_reg;
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized request traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 255;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state.
  int          streak;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic        exp_err;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (MAXS),
    .TIMEOUT      (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_done      (d_done),
    .d_rdata     (d_rdata),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    streak       = 0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    exp_err      = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, mem_valid, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_ifdone"}, if_done, 0);
    chk({tag, "_ddone"}, d_done, 0);
    chk({tag, "_ifrdata"}, if_rdata, 0);
    chk({tag, "_drdata"}, d_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, timeout_err, 0);
  endtask

  // Starts in an IDLE cycle with requests applied; returns in the DONE cycle.
  task automatic serve(input int lat, input logic [31:0] resp, output bit won_d);
    bit          is_d;
    logic [31:0] e_addr;
    logic        e_we;
    if (if_req && streak == MAXS) is_d = 1'b0;
    else if (d_req)               is_d = 1'b1;
    else                          is_d = 1'b0;
    if (!is_d)       streak = 0;
    else if (!if_req) streak = 0;
    else if (streak < MAXS) streak = streak + 1;
    e_addr = is_d ? d_addr : if_addr;
    e_we   = is_d ? d_we : 1'b0;
    tick();
    chk("grant_valid", mem_valid, 1);
    chk("grant_addr", mem_addr, e_addr);
    chk("grant_we", mem_we, e_we);
    if (is_d && d_we) chk("grant_wdata", mem_wdata, d_wdata);
    chk("grant_busy", busy, 1);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("hold_valid", mem_valid, 1);
      chk("hold_addr", mem_addr, e_addr);
      chk("hold_done", {30'd0, if_done, d_done}, 0);
    end
    mem_ready = 1'b1;
    mem_rdata = resp;
    tick();
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (is_d && !e_we) exp_d_rdata = resp;
    if (!is_d)         exp_if_rdata = resp;
    chk("done_if", if_done, !is_d);
    chk("done_d", d_done, is_d);
    chk("done_ifrdata", if_rdata, exp_if_rdata);
    chk("done_drdata", d_rdata, exp_d_rdata);
    chk("done_valid", mem_valid, 0);
    chk("done_busy", busy, 1);
    won_d = is_d;
  endtask

  task automatic finish_idle();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_pulse", {30'd0, if_done, d_done}, 0);
    chk("idle_err", timeout_err, exp_err);
  endtask

  initial begin
    bit won;
    int n;
    reset_n   = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Fetch only, two-cycle memory latency.
    if_req  = 1'b1;
    if_addr = 32'h40;
    serve(2, 32'h00A00093, won);
    chk("fetch_rdata", if_rdata, 32'h00A00093);
    if_req = 1'b0;
    finish_idle();

    // Collision: store wins first, fetch follows, d_rdata untouched.
    if_req  = 1'b1;
    if_addr = 32'h44;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEADBEEF;
    serve(1, 32'h11111111, won);
    chk("coll_first_d", won, 1);
    chk("coll_drdata", d_rdata, 32'h0);
    d_req = 1'b0;
    finish_idle();
    serve(2, 32'h00100113, won);
    if_req = 1'b0;
    finish_idle();

    // Starvation: data requests back to back while fetch waits.
    if_req  = 1'b1;
    if_addr = 32'h80;
    d_req   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_we    = 1'b0;
      d_addr  = 32'h200 + 32'(i * 4);
      serve(1 + (i % 2), 32'hA000_0000 + 32'(i), won);
      if (!won) if_req = 1'b0;
      finish_idle();
    end
    chk("starve_if_served", if_rdata, 32'hA000_0004);
    d_req = 1'b0;

    // Timeout on a load that never completes.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h300;
    tick();
    n = 0;
    while (mem_valid && n < 300) begin
      n++;
      tick();
    end
    chk("tmo_valid_cycles", n, TMO);
    chk("tmo_ddone", d_done, 1);
    chk("tmo_drdata", d_rdata, 0);
    chk("tmo_err", timeout_err, 1);
    exp_err     = 1'b1;
    exp_d_rdata = '0;
    streak      = 0;
    d_addr      = 32'h304;
    finish_idle();
    serve(3, 32'h5555AAAA, won);
    chk("tmo_after_rdata", d_rdata, 32'h5555AAAA);
    d_req = 1'b0;
    finish_idle();
    chk("tmo_sticky", timeout_err, 1);

    // Reset in the middle of a data transaction.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h400;
    tick();
    chk("rst_pre_valid", mem_valid, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    d_req = 1'b0;
    tick();
    chk("rst_hold_ddone", d_done, 0);
    reset_n = 1'b1;
    model_reset();
    tick();
    chk("rst_after_ddone", d_done, 0);
    if_req  = 1'b1;
    if_addr = 32'h500;
    serve(2, 32'hCAFEF00D, won);
    if_req = 1'b0;
    finish_idle();

    // Boundary: ready in the first busy cycle, then a stray ready in IDLE.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h600;
    d_wdata = 32'h12345678;
    serve(1, 32'hFFFFFFFF, won);
    d_req = 1'b0;
    finish_idle();
    mem_ready = 1'b1;
    mem_rdata = 32'h87654321;
    tick();
    mem_ready = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_valid", mem_valid, 0);
    chk("stray_pulse", {30'd0, if_done, d_done}, 0);
    tick();
    chk("stray_ifrdata", if_rdata, exp_if_rdata);
    chk("stray_drdata", d_rdata, exp_d_rdata);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      if (!if_req && !d_req) begin
        n = $urandom_range(1, 3);
        if (n[0]) begin
          if_req  = 1'b1;
          if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (n[1]) begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom;
          d_wdata = $urandom;
        end
      end
      serve($urandom_range(1, 4), $urandom, won);
      if (won) begin
        if ($urandom_range(0, 1) == 1) begin
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom;
          d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end else begin
        if_req = 1'b0;
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      finish_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
